// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with per-register pending-write scoreboard,
// two combinational read ports with optional write-through bypass.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_idx1,
    input  logic [AW-1:0]    rd_idx2,
    output logic [XLEN-1:0]  rd_data1,
    output logic [XLEN-1:0]  rd_data2,
    output logic             rd_busy1,
    output logic             rd_busy2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_idx,
    output logic             rsv_ok,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec,
    output logic [AW:0]      busy_cnt
);
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_cnt;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_set, w_clr, w_inc, w_dec, w_m1, w_m2;

    // A writeback to the very register being reserved frees it in the same cycle
    assign rsv_ok = rsv_en && (rsv_idx == '0 || !r_busy[rsv_idx] || (wr_en && wr_idx == rsv_idx));
    assign w_set  = rsv_ok && rsv_idx != '0 && !flush;
    assign w_clr  = wr_en && wr_idx != '0;
    assign w_inc  = w_set && !r_busy[rsv_idx];
    assign w_dec  = w_clr && r_busy[wr_idx] && !(w_set && rsv_idx == wr_idx);

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[wr_idx] = 1'b0;
        if (w_set) w_busy_nxt[rsv_idx] = 1'b1;
        if (flush) w_busy_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= flush ? '0 : r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
            if (w_clr) r_regs[wr_idx] <= wr_data;
        end
    end

    assign w_m1     = BYPASS && w_clr && wr_idx == rd_idx1;
    assign w_m2     = BYPASS && w_clr && wr_idx == rd_idx2;
    assign rd_data1 = w_m1 ? wr_data : (rd_idx1 == '0 ? '0 : r_regs[rd_idx1]);
    assign rd_data2 = w_m2 ? wr_data : (rd_idx2 == '0 ? '0 : r_regs[rd_idx2]);
    assign rd_busy1 = !w_m1 && r_busy[rd_idx1];
    assign rd_busy2 = !w_m2 && r_busy[rd_idx2];
    assign busy_vec = r_busy;
    assign busy_cnt = r_cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with a queued-expectation scoreboard,
// covering a BYPASS=1 and a BYPASS=0 instance driven by the same inputs.
module tb_regfile_scoreboard;
    logic        clk = 0, rst = 1;
    logic [4:0]  rd_idx1 = 0, rd_idx2 = 0, wr_idx = 0, rsv_idx = 0;
    logic        wr_en = 0, rsv_en = 0, flush = 0;
    logic [31:0] wr_data = 0;
    logic [31:0] rd_data1, rd_data2, b_rd_data1, b_rd_data2, busy_vec, b_busy_vec;
    logic        rd_busy1, rd_busy2, rsv_ok, b_rd_busy1, b_rd_busy2, b_rsv_ok;
    logic [5:0]  busy_cnt, b_busy_cnt;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0;
    event chk_ev;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1'b1)) u0 (
        .clk(clk), .rst(rst), .rd_idx1(rd_idx1), .rd_idx2(rd_idx2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_idx(rsv_idx),
        .rsv_ok(rsv_ok), .flush(flush), .busy_vec(busy_vec), .busy_cnt(busy_cnt));

    regfile_scoreboard #(.BYPASS(1'b0)) u1 (
        .clk(clk), .rst(rst), .rd_idx1(rd_idx1), .rd_idx2(rd_idx2),
        .rd_data1(b_rd_data1), .rd_data2(b_rd_data2), .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_idx(rsv_idx),
        .rsv_ok(b_rsv_ok), .flush(flush), .busy_vec(b_busy_vec), .busy_cnt(b_busy_cnt));

    function automatic logic [31:0] act(int s);
        case (s)
            0: return rd_data1;
            1: return {31'b0, rd_busy1};
            2: return rd_data2;
            3: return {31'b0, rd_busy2};
            4: return {31'b0, rsv_ok};
            5: return busy_vec;
            6: return {26'b0, busy_cnt};
            7: return b_rd_data1;
            8: return b_busy_vec;
            default: return {26'b0, b_busy_cnt};
        endcase
    endfunction

    task automatic push(string n, int s, logic [31:0] v);
        exp_t e;
        e.name = n; e.sel = s; e.val = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rsv_en = 0; flush = 0;
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() != 0) begin
                e = q.pop_front();
                a = act(e.sel);
                checks++;
                if (a !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, a, e.val, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // In reset: state cleared, reservations accepted without effect
        #2;
        rsv_en = 1; rsv_idx = 5;
        push("rst_rsv_ok", 4, 1); push("rst_cnt", 6, 0); push("rst_vec", 5, 0);
        ->chk_ev;
        #1 rsv_en = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            rd_idx1 = 5'(i); rd_idx2 = 5'(31 - i);
            push("rst_rd1", 0, 0); push("rst_busy1", 1, 0);
            push("rst_rd2", 2, 0); push("rst_busy2", 3, 0); push("rst_cnt", 6, 0);
        end
        // x0 is hardwired
        step();
        wr_en = 1; wr_idx = 0; wr_data = 32'hDEADBEEF; rd_idx1 = 0;
        push("x0_byp", 0, 0); push("x0_byp_busy", 1, 0);
        step(); idle();
        push("x0_rd", 0, 0); push("x0_rd_b0", 7, 0);
        // Reserve x5, retry rejected, writeback bypasses and clears
        step();
        rsv_en = 1; rsv_idx = 5; rd_idx1 = 5;
        push("rsv5_ok", 4, 1); push("rsv5_busy_pre", 1, 0);
        step();
        push("rsv5_again", 4, 0); push("rsv5_vec", 5, 32'h20);
        push("rsv5_cnt", 6, 1); push("rsv5_busy", 1, 1);
        step(); idle();
        wr_en = 1; wr_idx = 5; wr_data = 32'h1234;
        push("wr5_byp", 0, 32'h1234); push("wr5_byp_busy", 1, 0); push("wr5_b0_old", 7, 0);
        push("wr5_cnt_pre", 6, 1);
        step(); idle();
        push("wr5_cnt", 6, 0); push("wr5_vec", 5, 0); push("wr5_rd", 0, 32'h1234);
        push("wr5_b0_rd", 7, 32'h1234);
        // Same-cycle write and reserve on busy x7: reserve wins
        step();
        rsv_en = 1; rsv_idx = 7;
        push("rsv7_ok", 4, 1);
        step();
        wr_en = 1; wr_idx = 7; wr_data = 32'hA5A5A5A5; rsv_en = 1; rsv_idx = 7; rd_idx2 = 7;
        push("wr7rsv7_ok", 4, 1); push("wr7rsv7_cnt_pre", 6, 1);
        step(); idle();
        rd_idx1 = 7;
        push("wr7_data", 0, 32'hA5A5A5A5); push("wr7_busy", 1, 1);
        push("wr7_vec", 5, 32'h80); push("wr7_cnt", 6, 1);
        // Fill the scoreboard; x7 is still pending so its request bounces
        for (int i = 1; i < 32; i++) begin
            step();
            rsv_en = 1; rsv_idx = 5'(i);
            push("fill_ok", 4, (i == 7) ? 32'd0 : 32'd1);
        end
        step(); idle();
        push("fill_cnt", 6, 31); push("fill_vec", 5, 32'hFFFFFFFE);
        // Flush with a concurrent reserve and writeback
        step();
        flush = 1; rsv_en = 1; rsv_idx = 3; wr_en = 1; wr_idx = 4; wr_data = 9;
        step(); idle();
        rd_idx1 = 4; rd_idx2 = 3;
        push("flush_vec", 5, 0); push("flush_cnt", 6, 0); push("flush_x4", 0, 9);
        push("flush_x4_b0", 7, 9); push("flush_busy3", 3, 0); push("flush_b0_cnt", 9, 0);
        step();
        flush = 1; rsv_en = 1; rsv_idx = 10;
        push("flush_rsv_ok", 4, 1);
        step(); idle();
        push("flush_override_vec", 5, 0); push("flush_override_cnt", 6, 0);
        // Write-to-read latency on both builds
        step();
        wr_en = 1; wr_idx = 2; wr_data = 32'h55; rd_idx1 = 2;
        push("x2_byp", 0, 32'h55); push("x2_b0_old", 7, 0);
        step(); idle();
        push("x2_b0_new", 7, 32'h55);
        // Build up state then assert reset asynchronously mid-cycle
        for (int i = 1; i <= 4; i++) begin
            step();
            rsv_en = 1; rsv_idx = 5'(i);
        end
        step(); idle();
        wr_en = 1; wr_idx = 9; wr_data = 32'h77;
        step(); idle();
        rd_idx1 = 9;
        push("pre_rst_cnt", 6, 4); push("pre_rst_x9", 0, 32'h77); push("pre_rst_vec", 5, 32'h1E);
        push("pre_rst_b0_vec", 8, 32'h1E);
        @(negedge clk);
        step();
        #2 rst = 1;
        #1;
        push("async_rd", 0, 0); push("async_vec", 5, 0); push("async_cnt", 6, 0);
        push("async_b0_rd", 7, 0); push("async_b0_cnt", 9, 0);
        ->chk_ev;
        #1;
        @(negedge clk);
        rst = 0;
        step();
        push("post_rst_x9", 0, 0); push("post_rst_cnt", 6, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
